// File: rtl/bsg_axil_rd_arbiter.sv
// bsg_axil_rd_arbiter
//
// Shares one AXI-lite read slave port between num_masters_p AXI-lite read
// masters. Round-robin arbitration with at most one read in flight. The
// granted master's address goes to the slave, and the slave's response is
// returned to that master only. A response watchdog answers a hung read with
// SLVERR and err_data_p. It then drains the late slave response so that it is
// never delivered to anyone.
//
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   m_ar*                 per-master read address channels (packed by master)
//   m_r*                  per-master read data channels (packed by master)
//   s_ar*, s_r*           shared slave read address / data channels
//   grant_o               one-hot current owner, 0 when idle
//   timeout_o             one-cycle pulse when the watchdog fires
module bsg_axil_rd_arbiter #(
    parameter int          num_masters_p = 2,
    parameter int          timeout_p     = 1024,
    parameter logic [31:0] err_data_p    = 32'hDEAD_BEEF
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_masters_p-1:0][31:0]  m_araddr_i,
    input  logic [num_masters_p-1:0]        m_arvalid_i,
    output logic [num_masters_p-1:0]        m_arready_o,
    output logic [num_masters_p-1:0][31:0]  m_rdata_o,
    output logic [num_masters_p-1:0][1:0]   m_rresp_o,
    output logic [num_masters_p-1:0]        m_rvalid_o,
    input  logic [num_masters_p-1:0]        m_rready_i,
    output logic [31:0]                     s_araddr_o,
    output logic                            s_arvalid_o,
    input  logic                            s_arready_i,
    input  logic [31:0]                     s_rdata_i,
    input  logic [1:0]                      s_rresp_i,
    input  logic                            s_rvalid_i,
    output logic                            s_rready_o,
    output logic [num_masters_p-1:0]        grant_o,
    output logic                            timeout_o
);

    if (num_masters_p < 2) begin : g_bad_cfg
        $error("bsg_axil_rd_arbiter: num_masters_p must be at least 2");
    end

    localparam int lg_masters_lp = $clog2(num_masters_p);
    localparam int cnt_width_lp  = ($clog2(timeout_p + 1) > 1) ? $clog2(timeout_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_last_lp =
        (timeout_p == 0) ? '0 : cnt_width_lp'(timeout_p - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ERR,
        DRAIN
    } state_e;

    state_e                    state_q, state_d;
    logic [lg_masters_lp-1:0]  last_grant_q, last_grant_d;
    logic [31:0]               addr_q, addr_d;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
    logic [num_masters_p-1:0]  grant_q, grant_d;

    logic                      rr_found;
    logic [lg_masters_lp-1:0]  rr_pick;
    logic [lg_masters_lp-1:0]  rr_cand;
    logic                      r_done;
    logic                      expire;

    // last_grant_q doubles as the index of the current owner while busy.
    assign r_done = s_rvalid_i & m_rready_i[last_grant_q];

    // A slave response in the expiry cycle wins over the watchdog.
    assign expire = (timeout_p != 0) && (state_q == DATA) && !s_rvalid_i
                    && (cnt_q == cnt_last_lp);

    // Round-robin search starting one past the last winner, wrapping.
    // NOTE: every variable written in a combinational block gets a default at
    // the top, so no path through the block can leave it unassigned (latch).
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int i = 1; i <= num_masters_p; i++) begin
            rr_cand = lg_masters_lp'((int'(last_grant_q) + i) % num_masters_p);
            if (!rr_found && m_arvalid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // State register.
    // NOTE: sequential state is assigned with <= so every flop samples values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rr_found)    state_d = ADDR;
            ADDR:    if (s_arready_i) state_d = DATA;
            DATA: begin
                if (r_done)      state_d = IDLE;
                else if (expire) state_d = ERR;
            end
            ERR:     if (m_rready_i[last_grant_q]) state_d = DRAIN;
            DRAIN:   if (s_rvalid_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: owner, latched address and watchdog counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= lg_masters_lp'(num_masters_p - 1);
            addr_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    addr_d           = m_araddr_i[rr_pick];
                    grant_d          = '0;
                    grant_d[rr_pick] = 1'b1;
                    last_grant_d     = rr_pick;
                end
            end
            ADDR: begin
                if (s_arready_i) cnt_d = '0;
            end
            DATA: begin
                if (r_done) begin
                    grant_d = '0;
                end else if (cnt_q != '1) begin
                    // Saturate rather than wrap.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (s_rvalid_i) grant_d = '0;
            end
            default: ;
        endcase
    end

    // Output logic. Only the owner's channel is ever driven.
    always_comb begin
        m_arready_o = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        m_rresp_o   = '0;
        s_araddr_o  = '0;
        s_arvalid_o = 1'b0;
        s_rready_o  = 1'b0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so outputs stay low while reset is held.
                if (rr_found && reset_n_i) m_arready_o[rr_pick] = 1'b1;
            end
            ADDR: begin
                s_arvalid_o = 1'b1;
                s_araddr_o  = addr_q;
            end
            DATA: begin
                m_rvalid_o[last_grant_q] = s_rvalid_i;
                m_rdata_o[last_grant_q]  = s_rdata_i;
                m_rresp_o[last_grant_q]  = s_rresp_i;
                s_rready_o               = m_rready_i[last_grant_q];
                timeout_o                = expire;
            end
            ERR: begin
                m_rvalid_o[last_grant_q] = 1'b1;
                m_rdata_o[last_grant_q]  = err_data_p;
                m_rresp_o[last_grant_q]  = 2'b10;
            end
            DRAIN: begin
                s_rready_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_bsg_axil_rd_arbiter.sv
// Self-checking bench for bsg_axil_rd_arbiter (2 masters, 16-cycle watchdog).
// Read responses are predicted into a scoreboard when the slave side is
// driven. A negedge monitor pops the scoreboard on every master R handshake
// and also flags any rvalid seen on a master that does not own the grant.
module tb_bsg_axil_rd_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic [N-1:0][31:0]  m_araddr_i;
    logic [N-1:0]        m_arvalid_i;
    logic [N-1:0]        m_arready_o;
    logic [N-1:0][31:0]  m_rdata_o;
    logic [N-1:0][1:0]   m_rresp_o;
    logic [N-1:0]        m_rvalid_o;
    logic [N-1:0]        m_rready_i;
    logic [31:0]         s_araddr_o;
    logic                s_arvalid_o;
    logic                s_arready_i;
    logic [31:0]         s_rdata_i;
    logic [1:0]          s_rresp_i;
    logic                s_rvalid_i;
    logic                s_rready_o;
    logic [N-1:0]        grant_o;
    logic                timeout_o;

    always #5 clk_i = ~clk_i;

    bsg_axil_rd_arbiter #(
        .num_masters_p (N),
        .timeout_p     (TO),
        .err_data_p    (32'hDEAD_BEEF)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .m_araddr_i  (m_araddr_i),
        .m_arvalid_i (m_arvalid_i),
        .m_arready_o (m_arready_o),
        .m_rdata_o   (m_rdata_o),
        .m_rresp_o   (m_rresp_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_rready_i  (m_rready_i),
        .s_araddr_o  (s_araddr_o),
        .s_arvalid_o (s_arvalid_o),
        .s_arready_i (s_arready_i),
        .s_rdata_i   (s_rdata_i),
        .s_rresp_i   (s_rresp_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rready_o  (s_rready_o),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    typedef struct {
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;

    // Response monitor / scoreboard consumer.
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            for (int i = 0; i < N; i++) begin
                if (m_rvalid_o[i] && !grant_o[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL ungranted_rvalid: master %0d rvalid=1 with grant_o=%b, required rvalid=0",
                             i, grant_o);
                end
                if (m_rvalid_o[i] && m_rready_i[i]) begin
                    beats++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: master %0d data=%h resp=%b, none expected",
                                 i, m_rdata_o[i], m_rresp_o[i]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.m != i || m_rdata_o[i] !== mon_e.data || m_rresp_o[i] !== mon_e.resp) begin
                            errors++;
                            $display("FAIL r_beat: got master %0d data=%h resp=%b, required master %0d data=%h resp=%b",
                                     i, m_rdata_o[i], m_rresp_o[i], mon_e.m, mon_e.data, mon_e.resp);
                        end
                    end
                end
            end
        end
    end

    function automatic logic any_out();
        return |{m_arready_o, m_rvalid_o, m_rdata_o, m_rresp_o, s_araddr_o,
                 s_arvalid_o, s_rready_o, grant_o, timeout_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_araddr_i  = '0;
        m_arvalid_i = '0;
        m_rready_i  = '0;
        s_arready_i = 1'b0;
        s_rdata_i   = '0;
        s_rresp_i   = '0;
        s_rvalid_i  = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        tick();
    endtask

    // One complete read, entered in IDLE with master m's arvalid already up.
    task automatic serve(input int m, input int ar_delay, input logic [31:0] data,
                         input logic [1:0] resp, input bit drop);
        logic [31:0]  a;
        logic [N-1:0] oh;
        #1;
        a     = m_araddr_i[m];
        oh    = '0;
        oh[m] = 1'b1;
        checks++;
        if (m_arready_o !== oh || grant_o !== '0) begin
            errors++;
            $display("FAIL idle_pick: arready=%b grant=%b, required arready=%b grant=0",
                     m_arready_o, grant_o, oh);
        end
        tick();
        if (drop) m_arvalid_i[m] = 1'b0;
        checks++;
        if (grant_o !== oh || s_arvalid_o !== 1'b1 || s_araddr_o !== a) begin
            errors++;
            $display("FAIL addr_phase: grant=%b arvalid=%b araddr=%h, required grant=%b arvalid=1 araddr=%h",
                     grant_o, s_arvalid_o, s_araddr_o, oh, a);
        end
        for (int k = 0; k < ar_delay; k++) begin
            tick();
            checks++;
            if (s_arvalid_o !== 1'b1 || s_araddr_o !== a) begin
                errors++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h, required 1 / %h", s_arvalid_o, s_araddr_o, a);
            end
        end
        s_arready_i = 1'b1;
        tick();
        s_arready_i = 1'b0;
        sb.push_back('{m, data, resp});
        s_rdata_i  = data;
        s_rresp_i  = resp;
        s_rvalid_i = 1'b1;
        #1;
        checks++;
        if (grant_o !== oh || s_rready_o !== m_rready_i[m]) begin
            errors++;
            $display("FAIL data_phase: grant=%b rready=%b, required grant=%b rready=%b",
                     grant_o, s_rready_o, oh, m_rready_i[m]);
        end
        tick();
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        checks++;
        if (grant_o !== '0) begin
            errors++;
            $display("FAIL complete: grant=%b, required 0", grant_o);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty: %0d responses outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        clear_inputs();
        m_arvalid_i = '1;
        m_araddr_i  = {32'hAAAA_0000, 32'h5555_0000};
        m_rready_i  = '1;
        s_arready_i = 1'b1;
        s_rvalid_i  = 1'b1;
        #3;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: arready=%b grant=%b arvalid=%b, required all 0",
                     m_arready_o, grant_o, s_arvalid_o);
        end
        clear_inputs();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        tick();
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_valid: arready=%b grant=%b arvalid=%b, required all 0",
                     m_arready_o, grant_o, s_arvalid_o);
        end
    endtask

    task automatic test_single();
        apply_reset();
        m_rready_i     = '1;
        m_araddr_i[0]  = 32'h0000_1010;
        m_arvalid_i[0] = 1'b1;
        serve(0, 0, 32'h1234_5678, 2'b00, 1'b1);
        tick();
        check_sb_empty("single");
    endtask

    task automatic test_contention();
        apply_reset();
        m_rready_i  = '1;
        m_araddr_i  = {32'h0000_0200, 32'h0000_0100};
        m_arvalid_i = '1;
        for (int k = 0; k < 4; k++) begin
            serve(k % 2, 0, 32'hC0DE_0000 | 32'(k), 2'(k), 1'b0);
        end
        m_arvalid_i = '0;
        tick();
        checks++;
        if (grant_o !== '0) begin
            errors++;
            $display("FAIL contention_idle: grant=%b, required 0", grant_o);
        end
        check_sb_empty("contention");
    endtask

    task automatic test_back_pressure();
        int b0;
        apply_reset();
        m_rready_i     = '1;
        m_araddr_i[1]  = 32'h2000_0040;
        m_arvalid_i[1] = 1'b1;
        #1;
        checks++;
        if (m_arready_o !== 2'b10) begin
            errors++;
            $display("FAIL bp_pick: arready=%b, required 10", m_arready_o);
        end
        tick();
        m_arvalid_i[1] = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (s_arvalid_o !== 1'b1 || s_araddr_o !== 32'h2000_0040) begin
                errors++;
                $display("FAIL bp_ar_stable: arvalid=%b araddr=%h, required 1 / 20000040",
                         s_arvalid_o, s_araddr_o);
            end
            if (k < 5) tick();
        end
        s_arready_i = 1'b1;
        tick();
        s_arready_i   = 1'b0;
        b0            = beats;
        m_rready_i[1] = 1'b0;
        sb.push_back('{1, 32'h0BAD_CAFE, 2'b00});
        s_rdata_i  = 32'h0BAD_CAFE;
        s_rresp_i  = 2'b00;
        s_rvalid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (s_rready_o !== 1'b0 || m_rvalid_o[1] !== 1'b1 || m_rdata_o[1] !== 32'h0BAD_CAFE) begin
                errors++;
                $display("FAIL bp_stall: s_rready=%b rvalid=%b rdata=%h, required 0 / 1 / 0badcafe",
                         s_rready_o, m_rvalid_o[1], m_rdata_o[1]);
            end
            tick();
        end
        m_rready_i[1] = 1'b1;
        #1;
        checks++;
        if (s_rready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: s_rready=%b, required 1", s_rready_o);
        end
        tick();
        s_rvalid_i = 1'b0;
        checks++;
        if (beats - b0 != 1 || grant_o !== '0) begin
            errors++;
            $display("FAIL bp_one_beat: beats=%0d grant=%b, required 1 / 0", beats - b0, grant_o);
        end
        check_sb_empty("bp");
    endtask

    // Enter DATA for master 0 and sit through DATA cycles 1..15 without rvalid.
    task automatic run_to_data16(input string name);
        bit ok;
        m_rready_i     = '1;
        m_araddr_i[0]  = 32'h3000_0000;
        m_arvalid_i[0] = 1'b1;
        tick();
        m_arvalid_i[0] = 1'b0;
        s_arready_i    = 1'b1;
        tick();
        s_arready_i = 1'b0;
        ok = 1'b1;
        for (int c = 1; c < TO; c++) begin
            if (timeout_o !== 1'b0) ok = 1'b0;
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_early_timeout: timeout_o pulsed before DATA cycle 16, required 0", name);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset();
        run_to_data16("to");
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: timeout_o=%b in DATA cycle 16, required 1", timeout_o);
        end
        sb.push_back('{0, 32'hDEAD_BEEF, 2'b10});
        tick();
        checks++;
        if (timeout_o !== 1'b0 || s_rready_o !== 1'b0 || m_rvalid_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL to_err: timeout=%b s_rready=%b rvalid=%b, required 0 / 0 / 1",
                     timeout_o, s_rready_o, m_rvalid_o[0]);
        end
        tick();
        ok = 1'b1;
        for (int c = 18; c < 40; c++) begin
            if (s_rready_o !== 1'b1 || m_rvalid_o !== '0 || grant_o !== 2'b01) ok = 1'b0;
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_drain_wait: s_rready=%b rvalid=%b grant=%b, required 1 / 0 / 01",
                     s_rready_o, m_rvalid_o, grant_o);
        end
        s_rdata_i  = 32'hBAD0_0BAD;
        s_rresp_i  = 2'b00;
        s_rvalid_i = 1'b1;
        #1;
        checks++;
        if (s_rready_o !== 1'b1 || m_rvalid_o !== '0) begin
            errors++;
            $display("FAIL to_drain: s_rready=%b rvalid=%b, required 1 / 0", s_rready_o, m_rvalid_o);
        end
        tick();
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        checks++;
        if (grant_o !== '0 || m_rvalid_o !== '0 || s_rready_o !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: grant=%b rvalid=%b s_rready=%b, required 0", grant_o, m_rvalid_o, s_rready_o);
        end
        m_araddr_i[0]  = 32'h3000_0004;
        m_arvalid_i[0] = 1'b1;
        serve(0, 0, 32'h5555_AAAA, 2'b00, 1'b1);
        tick();
        check_sb_empty("to");
    endtask

    task automatic test_boundary();
        apply_reset();
        run_to_data16("bnd");
        sb.push_back('{0, 32'hCAFE_F00D, 2'b01});
        s_rdata_i  = 32'hCAFE_F00D;
        s_rresp_i  = 2'b01;
        s_rvalid_i = 1'b1;
        #1;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL bnd_no_timeout: timeout_o=%b, required 0", timeout_o);
        end
        tick();
        s_rvalid_i = 1'b0;
        checks++;
        if (grant_o !== '0 || timeout_o !== 1'b0 || m_rvalid_o !== '0) begin
            errors++;
            $display("FAIL bnd_idle: grant=%b timeout=%b rvalid=%b, required 0", grant_o, timeout_o, m_rvalid_o);
        end
        check_sb_empty("bnd");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_rready_i     = '1;
        m_araddr_i     = {32'h4000_1000, 32'h4000_0000};
        m_arvalid_i[0] = 1'b1;
        tick();
        m_arvalid_i[0] = 1'b0;
        s_arready_i    = 1'b1;
        tick();
        s_arready_i = 1'b0;
        m_arvalid_i = '1;
        s_rdata_i   = 32'hFFFF_FFFF;
        s_rresp_i   = 2'b11;
        s_rvalid_i  = 1'b1;
        #1;
        checks++;
        if (m_rvalid_o !== 2'b01) begin
            errors++;
            $display("FAIL mid_data: rvalid=%b, required 01", m_rvalid_o);
        end
        #1;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rvalid=%b rdata0=%h s_rready=%b grant=%b arready=%b, required all 0",
                     m_rvalid_o, m_rdata_o[0], s_rready_o, grant_o, m_arready_o);
        end
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        s_rresp_i  = '0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        serve(0, 0, 32'h0101_0101, 2'b00, 1'b1);
        m_arvalid_i = '0;
        tick();
        check_sb_empty("mid");
    endtask

    initial begin
        reset_n_i = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
